// File: rtl/instr_buffer_multi.sv
// -----------------------------------------------------------------------------
// instr_buffer_multi
//   Multi-lane instruction buffer between the fetch unit and decode. Each cycle
//   up to IN_WIDTH fetched entries are pushed. Valid lanes are compacted into
//   consecutive slots. Up to OUT_WIDTH of the oldest entries are offered to
//   decode in program order, and decode consumes them as a prefix.
//
//   Optional feature: define IB_PERF_CNT_EN to add a saturating 32-bit counter
//   of cycles in which fetch offered work but was stalled (stall_cycles_o).
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset
//   flush_i             discard all contents; has priority over push and pop
//   frontend_instr_i    IN_WIDTH fetch payloads, lane 0 oldest
//   frontend_valid_i    per-lane fetch valid
//   frontend_stallreq_o buffer cannot take a full fetch group this cycle
//   backend_instr_o     OUT_WIDTH oldest entries, lane 0 oldest
//   backend_valid_o     lane k holds a real entry
//   backend_accept_i    decode consumed lanes; only the leading-ones prefix counts
//   occupancy_o         current entry count
//   stall_cycles_o      (IB_PERF_CNT_EN only) saturating stall-cycle counter
// -----------------------------------------------------------------------------
package instr_buffer_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bp_taken;
    logic        fetch_fault;
  } instr_buffer_info_t;
endpackage

module instr_buffer_multi #(
  parameter int IN_WIDTH    = 4,
  parameter int OUT_WIDTH   = 2,
  parameter int DEPTH       = 16,
  parameter int ENTRY_WIDTH = $bits(instr_buffer_pkg::instr_buffer_info_t)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [IN_WIDTH-1:0][ENTRY_WIDTH-1:0]  frontend_instr_i,
  input  logic [IN_WIDTH-1:0]                   frontend_valid_i,
  output logic                                  frontend_stallreq_o,
  output logic [OUT_WIDTH-1:0][ENTRY_WIDTH-1:0] backend_instr_o,
  output logic [OUT_WIDTH-1:0]                  backend_valid_o,
  input  logic [OUT_WIDTH-1:0]                  backend_accept_i,
  output logic [$clog2(DEPTH):0]                occupancy_o
`ifdef IB_PERF_CNT_EN
  ,
  output logic [31:0]                           stall_cycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Registered state
  logic [ENTRY_WIDTH-1:0] r_storage [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;

  // Combinational helpers
  logic [CNT_W-1:0]       w_free;
  logic                   w_stall;
  logic                   w_push;
  logic [PTR_W-1:0]       w_lane_off [IN_WIDTH];
  logic [CNT_W-1:0]       w_valid_cnt;
  logic [CNT_W-1:0]       w_pushed;
  logic [OUT_WIDTH-1:0]   w_out_valid;
  logic                   w_run;
  logic [CNT_W-1:0]       w_popped;

  // Stall looks only at the registered count: a pop in the same cycle earns
  // no credit, which keeps this path short and fetch-side timing independent
  // of decode.
  assign w_free  = CNT_W'(DEPTH) - r_count;
  assign w_stall = w_free < CNT_W'(IN_WIDTH);
  assign w_push  = !flush_i && !w_stall;

  // Lane compaction: each valid lane lands at wr_ptr + (number of valid lanes
  // below it). The running sum is the total push size once the loop ends.
  // NOTE: blocking assignments are correct here; w_valid_cnt is a running
  // combinational accumulator, not state, and is defaulted before the loop so
  // no latch is inferred.
  always_comb begin
    w_valid_cnt = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_lane_off[i] = w_valid_cnt[PTR_W-1:0];
      w_valid_cnt   = w_valid_cnt + CNT_W'(frontend_valid_i[i]);
    end
  end

  assign w_pushed = w_push ? w_valid_cnt : '0;

  // Output lanes are read straight from storage; no same-cycle bypass.
  always_comb begin
    for (int k = 0; k < OUT_WIDTH; k++) begin
      backend_instr_o[k] = r_storage[r_rd_ptr + PTR_W'(k)];
      w_out_valid[k]     = r_count > CNT_W'(k);
    end
  end

  assign backend_valid_o = w_out_valid;

  // Pop count = leading ones of (accept & valid). The run flag drops at the
  // first lane that is not both valid and accepted, so later bits are ignored.
  always_comb begin
    w_run    = 1'b1;
    w_popped = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      w_run    = w_run & backend_accept_i[k] & w_out_valid[k];
      w_popped = w_popped + CNT_W'(w_run);
    end
  end

  // Pointers and count. Pointer arithmetic wraps naturally at DEPTH because
  // DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_popped);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_pushed);
      r_count  <= r_count + w_pushed - w_popped;
    end
  end

  // NOTE: the storage array is deliberately left without reset; validity
  // comes entirely from the count, so clearing the array would only cost
  // reset fan-out and block RAM inference.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (w_push && frontend_valid_i[i]) begin
        r_storage[r_wr_ptr + w_lane_off[i]] <= frontend_instr_i[i];
      end
    end
  end

  assign frontend_stallreq_o = w_stall;
  assign occupancy_o         = r_count;

`ifdef IB_PERF_CNT_EN
  // Counts cycles where fetch had work but was held off. Flush leaves it alone.
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (|frontend_valid_i) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
`endif

endmodule

// File: tb/tb_instr_buffer_multi.sv
// -----------------------------------------------------------------------------
// tb_instr_buffer_multi
//   Directed bench for instr_buffer_multi at DEPTH=8, IN_WIDTH=4, OUT_WIDTH=2.
//   A queue model predicts outputs each cycle; literal checks pin key points.
// -----------------------------------------------------------------------------
module tb_instr_buffer_multi;
  import instr_buffer_pkg::*;

  localparam int IW = 4;
  localparam int OW = 2;
  localparam int D  = 8;
  localparam int EW = $bits(instr_buffer_info_t);

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush_i;
  logic [IW-1:0][EW-1:0]     frontend_instr_i;
  logic [IW-1:0]             frontend_valid_i;
  logic                      frontend_stallreq_o;
  logic [OW-1:0][EW-1:0]     backend_instr_o;
  logic [OW-1:0]             backend_valid_o;
  logic [OW-1:0]             backend_accept_i;
  logic [3:0]                occupancy_o;
`ifdef IB_PERF_CNT_EN
  logic [31:0]               stall_cycles_o;
`endif

  instr_buffer_multi #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .DEPTH    (D)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .frontend_instr_i   (frontend_instr_i),
    .frontend_valid_i   (frontend_valid_i),
    .frontend_stallreq_o(frontend_stallreq_o),
    .backend_instr_o    (backend_instr_o),
    .backend_valid_o    (backend_valid_o),
    .backend_accept_i   (backend_accept_i),
    .occupancy_o        (occupancy_o)
`ifdef IB_PERF_CNT_EN
    ,
    .stall_cycles_o     (stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_buffer_info_t mk(input int id);
    instr_buffer_info_t e;
    e.pc          = 32'h0000_1000 + 32'(id) * 4;
    e.instr       = 32'hA000_0000 | 32'(id);
    e.bp_taken    = id[0];
    e.fetch_fault = id[1];
    return e;
  endfunction

  // ---------------- behavioural model ----------------
  // The buffer is just an ordered queue: pop from the front, append valid
  // lanes at the back, empty on flush or reset.
  instr_buffer_info_t m_q[$];
  int unsigned        m_stall_cnt;
  int                 m_pop;
  bit                 m_stall;

  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      m_stall_cnt = 0;
    end else begin
      m_stall = (D - m_q.size()) < IW;
      check("m_occ",   64'(occupancy_o), 64'(m_q.size()));
      check("m_stall", 64'(frontend_stallreq_o), 64'(m_stall));
      for (int k = 0; k < OW; k++) begin
        check("m_valid", 64'(backend_valid_o[k]), 64'(m_q.size() > k));
        if (m_q.size() > k) check("m_instr", 128'(backend_instr_o[k]), 128'(m_q[k]));
      end
`ifdef IB_PERF_CNT_EN
      check("m_perf", 64'(stall_cycles_o), 64'(m_stall_cnt));
      if (m_stall && (|frontend_valid_i) && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
`endif
      if (flush_i) begin
        m_q.delete();
      end else begin
        m_pop = 0;
        for (int k = 0; k < OW; k++) begin
          if (backend_accept_i[k] && k < m_q.size() && m_pop == k) m_pop++;
        end
        for (int k = 0; k < m_pop; k++) void'(m_q.pop_front());
        if (!m_stall) begin
          for (int i = 0; i < IW; i++)
            if (frontend_valid_i[i]) m_q.push_back(instr_buffer_info_t'(frontend_instr_i[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic fl, input logic [3:0] v,
                      input instr_buffer_info_t d0, input instr_buffer_info_t d1,
                      input instr_buffer_info_t d2, input instr_buffer_info_t d3,
                      input logic [1:0] acc);
    flush_i             = fl;
    frontend_valid_i    = v;
    frontend_instr_i[0] = d0;
    frontend_instr_i[1] = d1;
    frontend_instr_i[2] = d2;
    frontend_instr_i[3] = d3;
    backend_accept_i    = acc;
    @(posedge clk);
    #1;
  endtask

  instr_buffer_info_t junk;
  int                 nid;
  bit                 will_push;
  int unsigned        perf_before;

  initial begin
    junk             = mk(99);
    rst              = 1'b1;
    flush_i          = 1'b0;
    frontend_valid_i = '0;
    frontend_instr_i = '0;
    backend_accept_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ",   64'(occupancy_o), 64'd0);
    check("rst_valid", 64'(backend_valid_o), 64'd0);
    check("rst_stall", 64'(frontend_stallreq_o), 64'd0);
    rst = 1'b0;

    // Full group, no pop
    step(0, 4'b1111, mk(1), mk(2), mk(3), mk(4), 2'b00);
    check("push4_occ",   64'(occupancy_o), 64'd4);
    check("push4_valid", 64'(backend_valid_o), 64'b11);
    check("push4_out0",  128'(backend_instr_o[0]), 128'(mk(1)));
    check("push4_out1",  128'(backend_instr_o[1]), 128'(mk(2)));
    check("push4_stall", 64'(frontend_stallreq_o), 64'd0);

    step(1, 4'b0000, junk, junk, junk, junk, 2'b00);
    check("flush_empty", 64'(occupancy_o), 64'd0);

    // Compaction: lanes 1 and 3 only
    step(0, 4'b1010, junk, mk(10), junk, mk(11), 2'b00);
    check("cmp_occ",  64'(occupancy_o), 64'd2);
    check("cmp_out0", 128'(backend_instr_o[0]), 128'(mk(10)));
    check("cmp_out1", 128'(backend_instr_o[1]), 128'(mk(11)));

    // Fill to 8
    step(0, 4'b0011, mk(12), mk(13), junk, junk, 2'b00);
    check("fill4_stall", 64'(frontend_stallreq_o), 64'd0);
    step(0, 4'b1111, mk(14), mk(15), mk(16), mk(17), 2'b00);
    check("full_occ",   64'(occupancy_o), 64'd8);
    check("full_stall", 64'(frontend_stallreq_o), 64'd1);

    // Push while full with a pop: push rejected
    step(0, 4'b1111, mk(18), mk(19), mk(20), mk(21), 2'b11);
    check("rej_occ",   64'(occupancy_o), 64'd6);
    check("rej_stall", 64'(frontend_stallreq_o), 64'd1);
    check("rej_out0",  128'(backend_instr_o[0]), 128'(mk(12)));
    step(0, 4'b0000, junk, junk, junk, junk, 2'b11);
    check("occ4_stall", 64'(frontend_stallreq_o), 64'd0);
    check("occ4_out0",  128'(backend_instr_o[0]), 128'(mk(14)));
    step(0, 4'b0000, junk, junk, junk, junk, 2'b11);

    // Prefix pop: accept=10 pops nothing, then accept=01 pops one
    step(0, 4'b0000, junk, junk, junk, junk, 2'b10);
    check("pfx10_occ",  64'(occupancy_o), 64'd2);
    check("pfx10_out0", 128'(backend_instr_o[0]), 128'(mk(16)));
    step(0, 4'b0000, junk, junk, junk, junk, 2'b01);
    check("pfx01_occ",   64'(occupancy_o), 64'd1);
    check("pfx01_out0",  128'(backend_instr_o[0]), 128'(mk(17)));
    check("pfx01_valid", 64'(backend_valid_o), 64'b01);
    // Accepting an invalid lane is harmless
    step(0, 4'b0000, junk, junk, junk, junk, 2'b11);
    check("ovpop_occ", 64'(occupancy_o), 64'd0);

    // Wrap-around streaming: push 4 / pop 2, ids advance only when accepted
    nid = 100;
    for (int c = 0; c < 14; c++) begin
      will_push = (D - m_q.size()) >= IW;
      step(0, 4'b1111, mk(nid), mk(nid + 1), mk(nid + 2), mk(nid + 3), 2'b11);
      if (will_push) nid += 4;
    end
    for (int c = 0; c < 20 && m_q.size() != 0; c++)
      step(0, 4'b0000, junk, junk, junk, junk, 2'b11);
    check("drain_occ", 64'(occupancy_o), 64'd0);

    // Flush with concurrent push and pop at count 6
    step(0, 4'b1111, mk(200), mk(201), mk(202), mk(203), 2'b00);
    step(0, 4'b0011, mk(204), mk(205), junk, junk, 2'b00);
    check("pre_fl_occ",   64'(occupancy_o), 64'd6);
    check("pre_fl_stall", 64'(frontend_stallreq_o), 64'd1);
    perf_before = m_stall_cnt;
    step(1, 4'b1111, mk(206), mk(207), mk(208), mk(209), 2'b11);
    check("fl_occ",   64'(occupancy_o), 64'd0);
    check("fl_valid", 64'(backend_valid_o), 64'd0);
`ifdef IB_PERF_CNT_EN
    check("fl_perf_kept", 64'(stall_cycles_o), 64'(perf_before + 1));
`endif
    step(0, 4'b0011, mk(30), mk(31), junk, junk, 2'b00);
    check("ef_occ",  64'(occupancy_o), 64'd2);
    check("ef_out0", 128'(backend_instr_o[0]), 128'(mk(30)));
    check("ef_out1", 128'(backend_instr_o[1]), 128'(mk(31)));

    step(0, 4'b0000, junk, junk, junk, junk, 2'b00);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
